// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the step/direction/enable generator:
//   - FSM state encoding (localparams and the enum built from them)
//   - default timing constants for direction setup and step high time
//   - the driver enable polarity and a helper that maps on/off to a pin level
// -----------------------------------------------------------------------------
package stepper_pkg;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_SETUP_ENC = 2'd1;
   localparam logic [1:0] ST_HIGH_ENC  = 2'd2;
   localparam logic [1:0] ST_LOW_ENC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_SETUP = ST_SETUP_ENC,
      ST_HIGH  = ST_HIGH_ENC,
      ST_LOW   = ST_LOW_ENC
   } state_e;

   localparam int DEFAULT_DIR_SETUP_CYCLES = 50;
   localparam int DEFAULT_STEP_HIGH_CYCLES = 100;

   // The motor driver enable pin is active-low.
   localparam logic ENABLE_ACTIVE = 1'b0;

   function automatic logic enable_level(input logic on);
      return on ? ENABLE_ACTIVE : ~ENABLE_ACTIVE;
   endfunction

endpackage

// File: rtl/stepper_pulse_gen_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down counter with a zero flag, shared by the SETUP, HIGH and LOW
// phases. Loading value N makes zero_o rise N cycles later, so a phase of C
// cycles is started by loading C-1 and ends in the cycle zero_o is high.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   value to load
//   zero_o       counter is zero
// -----------------------------------------------------------------------------
module phase_timer
   import stepper_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   // NOTE: count_d starts from the held value, so every path assigns it and
   // no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // NOTE: flops use non-blocking assignments so every register samples the
   // values from before the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/stepper_pulse_gen.sv
// -----------------------------------------------------------------------------
// stepper_pulse_gen
// Single-axis step/direction/enable generator. Accepts one move command
// (steps, direction, period) and produces driver signals with a guaranteed
// direction setup time and step high time.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready           command handshake (ready == IDLE)
//   cmd_steps, cmd_direction,
//   cmd_period                      move command fields
//   inversion                       motor inversion bit
//   hold_enable                     keep driver enabled after a move
//   abort                           stop at the next safe point
//   stepper_enable (active low),
//   stepper_step, stepper_direction driver outputs (registered)
//   busy, done, aborted,
//   steps_remaining                 status
// -----------------------------------------------------------------------------
module stepper_pulse_gen
   import stepper_pkg::*;
#(
   parameter int DIR_SETUP_CYCLES = DEFAULT_DIR_SETUP_CYCLES,
   parameter int STEP_HIGH_CYCLES = DEFAULT_STEP_HIGH_CYCLES,
   parameter int PERIOD_W         = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [31:0]         cmd_steps,
   input  logic                cmd_direction,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                inversion,
   input  logic                hold_enable,
   input  logic                abort,
   output logic                stepper_enable,
   output logic                stepper_step,
   output logic                stepper_direction,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [31:0]         steps_remaining
);

   // Shortest legal period leaves at least one LOW cycle.
   localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(STEP_HIGH_CYCLES + 1);
   localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] HIGH_LOAD  = PERIOD_W'(STEP_HIGH_CYCLES - 1);

   state_e              state_q, state_d;
   logic                step_q, step_d;
   logic                dir_q, dir_d;
   logic                en_q, en_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                abort_pend_q, abort_pend_d;
   logic [31:0]         steps_q, steps_d;
   logic [PERIOD_W-1:0] period_q, period_d;

   logic                tmr_load;
   logic [PERIOD_W-1:0] tmr_val;
   logic                tmr_zero;

   logic                go_high;
   logic                go_idle;
   logic                end_aborted;

   phase_timer #(.W(PERIOD_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      dir_d        = dir_q;
      en_d         = en_q;
      done_d       = 1'b0;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      steps_d      = steps_q;
      period_d     = period_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      go_high      = 1'b0;
      go_idle      = 1'b0;
      end_aborted  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               aborted_d = 1'b0;
               steps_d   = cmd_steps;
               if (cmd_steps == '0) begin
                  // Nothing to move: report completion, leave the pins alone.
                  done_d = 1'b1;
               end else begin
                  state_d  = ST_SETUP;
                  dir_d    = cmd_direction ^ inversion;
                  en_d     = ENABLE_ACTIVE;
                  period_d = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
                  tmr_load = 1'b1;
                  tmr_val  = SETUP_LOAD;
               end
            end
         end

         ST_SETUP: begin
            if (abort) begin
               go_idle     = 1'b1;
               end_aborted = 1'b1;
            end else if (tmr_zero) begin
               go_high = 1'b1;
            end
         end

         ST_HIGH: begin
            // An abort during the pulse is remembered so the pulse keeps its
            // full width; the move ends when the high time runs out.
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            if (tmr_zero) begin
               step_d = 1'b0;
               if (abort || abort_pend_q) begin
                  go_idle     = 1'b1;
                  end_aborted = 1'b1;
               end else begin
                  state_d  = ST_LOW;
                  tmr_load = 1'b1;
                  // LOW lasts period - high cycles, so load one less.
                  tmr_val  = period_q - MIN_PERIOD;
               end
            end
         end

         ST_LOW: begin
            if (abort) begin
               go_idle     = 1'b1;
               end_aborted = 1'b1;
            end else if (tmr_zero) begin
               if (steps_q != '0) begin
                  go_high = 1'b1;
               end else begin
                  go_idle = 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (go_high) begin
         state_d  = ST_HIGH;
         step_d   = 1'b1;
         steps_d  = steps_q - 32'd1;
         tmr_load = 1'b1;
         tmr_val  = HIGH_LOAD;
      end

      if (go_idle) begin
         state_d      = ST_IDLE;
         step_d       = 1'b0;
         done_d       = 1'b1;
         aborted_d    = end_aborted;
         abort_pend_d = 1'b0;
         en_d         = enable_level(hold_enable);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         step_q       <= 1'b0;
         dir_q        <= 1'b0;
         en_q         <= ~ENABLE_ACTIVE;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         steps_q      <= '0;
         period_q     <= MIN_PERIOD;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         dir_q        <= dir_d;
         en_q         <= en_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
         steps_q      <= steps_d;
         period_q     <= period_d;
      end
   end

   assign cmd_ready         = (state_q == ST_IDLE);
   assign busy              = (state_q != ST_IDLE);
   assign stepper_step      = step_q;
   assign stepper_direction = dir_q;
   assign stepper_enable    = en_q;
   assign done              = done_q;
   assign aborted           = aborted_q;
   assign steps_remaining   = steps_q;

endmodule

// File: doc/stepper_pulse_gen.md
# stepper_pulse_gen

Single-axis step/direction/enable generator. It turns one move command (step count, direction, step period) into motor driver signals with guaranteed direction setup time and step pulse width. It is the driving end of the stepper interface: its outputs feed the motor driver and the position tracker, which counts a step on each rising edge of step while enable is low. When direction XOR inversion is 0, the tracker counts +1.

## Interface
Parameters:
- DIR_SETUP_CYCLES, 50: clocks from direction and enable becoming valid to the first step rising edge; must be ≥1.
- STEP_HIGH_CYCLES, 100: step pulse high time in clocks; must be ≥1.
- PERIOD_W, 32: width of cmd_period.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  block can accept a command; high exactly when state is IDLE.
- cmd_steps  in  32  number of steps, unsigned.
- cmd_direction  in  1  0 = positive move, 1 = negative move.
- cmd_period  in  PERIOD_W  step period in clocks.
- inversion  in  1  motor inversion bit; the same value is given to the position tracker.
- hold_enable  in  1  1 = keep the motor enabled while idle after a move.
- abort  in  1  stop the move at the next safe point.
- stepper_enable  out  1  active-low driver enable.
- stepper_step  out  1  step pulse.
- stepper_direction  out  1  equals cmd_direction XOR inversion.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a move finishes.
- aborted  out  1  the last move ended by abort; valid from done until the next accept.
- steps_remaining  out  32  steps not yet issued.

## Operation
- States: IDLE, SETUP, HIGH, LOW.
- Command accept:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - cmd_steps, the effective period, and the direction are latched.
  - Effective period = max(cmd_period, STEP_HIGH_CYCLES+1).
- Zero-step command (cmd_steps == 0): done pulses on the next cycle and state stays IDLE. There are no step pulses and stepper_enable is unchanged.
- Nonzero command, IDLE→SETUP:
  - stepper_direction is set to cmd_direction ^ inversion.
  - stepper_enable is driven to 0.
  - steps_remaining is set to cmd_steps.
- SETUP: lasts DIR_SETUP_CYCLES cycles, then goes to HIGH.
- Entering HIGH: stepper_step goes to 1 and steps_remaining decrements. HIGH lasts STEP_HIGH_CYCLES cycles.
- LOW: stepper_step is 0 for (effective period − STEP_HIGH_CYCLES) cycles. Then:
  - if steps_remaining ≠ 0, go to HIGH;
  - otherwise go to IDLE, pulse done, and drive stepper_enable to ~hold_enable.
- stepper_direction changes only at accept in IDLE, never while step is high or during a move.
- Abort:
  - In SETUP or LOW: go to IDLE on the next cycle with done=1 and aborted=1.
  - In HIGH: finish the full high time (no runt pulse), then go to IDLE with done and aborted set.
  - steps_remaining keeps the count not yet issued.
  - In IDLE, abort has no effect.
- Reset mid-move: all outputs take their reset values immediately. The partial pulse is dropped, and no done is issued.
- Reset values:
  - stepper_step=0, stepper_direction=0, stepper_enable=1;
  - busy=0, done=0, aborted=0, steps_remaining=0;
  - cmd_ready=1 once reset is released.

## Timing
- Accept at cycle 0: direction and enable are valid at cycle 1.
- The first step rising edge is at cycle 1+DIR_SETUP_CYCLES.
- Rising edges are spaced by exactly the effective period.
- For N steps at period P, done is high at cycle 1+DIR_SETUP_CYCLES+N·P, together with cmd_ready=1.
- Back-to-back accept is allowed in the done cycle. The new move's direction appears no earlier than P−STEP_HIGH_CYCLES clocks after the last step falling edge.
- All outputs are registered. There is no combinational path from inputs to outputs except cmd_ready, which is decoded from state.

## Structure
- Shared package stepper_pkg holds:
  - the state encoding localparams;
  - default timing constants (DIR_SETUP_CYCLES, STEP_HIGH_CYCLES);
  - the enable-active-low convention constant.
- Sub-module phase_timer: a loadable down counter with a zero flag. It is shared by the SETUP, HIGH and LOW phases.
- The top level contains the FSM, the step counter and the output registers.

## Test plan
All scenarios use DIR_SETUP_CYCLES=2 and STEP_HIGH_CYCLES=3.
- Reset release: step=0, dir=0, enable=1, busy=0, cmd_ready=1. Assert reset in the middle of a HIGH phase → step drops to 0 asynchronously and done never pulses.
- steps=4, dir=0, period=10, inversion=0:
  - rising edges at cycles 3, 13, 23, 33, each 3 cycles high;
  - done at cycle 43;
  - position tracker pos = +4.
- steps=3, dir=1, inversion=1, period=8: stepper_direction=0 and the tracker (inversion=1) ends at −3. With hold_enable=1, enable stays 0 after done; with hold_enable=0 it returns to 1.
- steps=0 → done at cycle 1, no step edges, enable unchanged. period=2 with steps=2 → rising edges 4 cycles apart (period clamped).
- steps=10, period=10: abort in cycle 14 (HIGH) → the pulse stays high through cycle 15, done at cycle 16, aborted=1, steps_remaining=8, tracker advanced by 2.
- Two back-to-back commands, with cmd_valid held high → the second is accepted in the first command's done cycle and the total step count is correct.
